// File: rtl/c_mac_feeder.sv
// Operand feeder for one complex MAC: buffers VLEN operand pairs, clears the MAC,
// streams the pairs with mac_en, waits for the dot product and hands it downstream.
module c_mac_feeder #(
    parameter int N       = 16,
    parameter int VLEN    = 4,
    parameter int ACC_W   = 32,
    parameter int TIMEOUT = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic [N-1:0]     ld_ar,
    input  logic [N-1:0]     ld_ai,
    input  logic [N-1:0]     ld_br,
    input  logic [N-1:0]     ld_bi,
    output logic             mac_clear,
    output logic             mac_en,
    output logic [N-1:0]     mac_ar,
    output logic [N-1:0]     mac_ai,
    output logic [N-1:0]     mac_br,
    output logic [N-1:0]     mac_bi,
    input  logic             mac_result_valid,
    input  logic [ACC_W-1:0] mac_r_out,
    input  logic [ACC_W-1:0] mac_i_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [ACC_W-1:0] res_r,
    output logic [ACC_W-1:0] res_i,
    output logic             err_timeout,
    output logic             err_spurious,
    input  logic             err_clr
);

    localparam int IDX_W = (VLEN > 1) ? $clog2(VLEN) : 1;
    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    // Handshakes: a transfer happens on a rising clk edge where valid && ready;
    // valid holds its payload stable until then, ready may change freely.
    typedef enum logic [2:0] {
        S_FILL,
        S_CLEAR,
        S_ISSUE,
        S_WAIT,
        S_OUT
    } state_t;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] wr_idx, wr_idx_nxt;
    logic [IDX_W-1:0] rd_idx, rd_idx_nxt;
    logic [TMR_W-1:0] timer, timer_nxt;
    logic             aborting, aborting_nxt;
    logic             accept;
    logic             capture;
    logic             timeout_evt;
    logic             spurious_evt;
    logic [4*N-1:0]   pair_buf [VLEN];

    assign accept       = ld_valid && ld_ready;
    assign spurious_evt = mac_result_valid && (state != S_WAIT);

    always_comb begin
        state_nxt    = state;
        wr_idx_nxt   = wr_idx;
        rd_idx_nxt   = rd_idx;
        timer_nxt    = timer;
        aborting_nxt = aborting;
        capture      = 1'b0;
        timeout_evt  = 1'b0;
        unique case (state)
            S_FILL: begin
                if (accept) begin
                    if (wr_idx == IDX_W'(VLEN - 1)) begin
                        wr_idx_nxt = '0;
                        state_nxt  = S_CLEAR;
                    end else begin
                        wr_idx_nxt = wr_idx + IDX_W'(1);
                    end
                end
            end
            S_CLEAR: begin
                // A clear that follows a timeout discards the buffer instead of issuing.
                rd_idx_nxt   = '0;
                aborting_nxt = 1'b0;
                state_nxt    = aborting ? S_FILL : S_ISSUE;
            end
            S_ISSUE: begin
                if (rd_idx == IDX_W'(VLEN - 1)) begin
                    rd_idx_nxt = '0;
                    timer_nxt  = '0;
                    state_nxt  = S_WAIT;
                end else begin
                    rd_idx_nxt = rd_idx + IDX_W'(1);
                end
            end
            S_WAIT: begin
                // A result on the final timer cycle still wins over the timeout.
                if (mac_result_valid) begin
                    capture   = 1'b1;
                    state_nxt = S_OUT;
                end else if (timer == TMR_W'(TIMEOUT - 1)) begin
                    timeout_evt  = 1'b1;
                    aborting_nxt = 1'b1;
                    state_nxt    = S_CLEAR;
                end else begin
                    timer_nxt = timer + TMR_W'(1);
                end
            end
            S_OUT: begin
                if (res_ready) begin
                    state_nxt = S_FILL;
                end
            end
            default: state_nxt = S_FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_FILL;
            wr_idx       <= '0;
            rd_idx       <= '0;
            timer        <= '0;
            aborting     <= 1'b0;
            ld_ready     <= 1'b0;
            mac_clear    <= 1'b0;
            mac_en       <= 1'b0;
            mac_ar       <= '0;
            mac_ai       <= '0;
            mac_br       <= '0;
            mac_bi       <= '0;
            res_valid    <= 1'b0;
            res_r        <= '0;
            res_i        <= '0;
            err_timeout  <= 1'b0;
            err_spurious <= 1'b0;
        end else begin
            state     <= state_nxt;
            wr_idx    <= wr_idx_nxt;
            rd_idx    <= rd_idx_nxt;
            timer     <= timer_nxt;
            aborting  <= aborting_nxt;
            // Outputs are registered copies of what the next state asks for.
            ld_ready  <= (state_nxt == S_FILL);
            mac_clear <= (state_nxt == S_CLEAR);
            mac_en    <= (state_nxt == S_ISSUE);
            res_valid <= (state_nxt == S_OUT);
            if (state_nxt == S_ISSUE) begin
                {mac_ar, mac_ai, mac_br, mac_bi} <= pair_buf[rd_idx_nxt];
            end
            if (capture) begin
                res_r <= mac_r_out;
                res_i <= mac_i_out;
            end
            err_timeout  <= timeout_evt  || (err_timeout  && !err_clr);
            err_spurious <= spurious_evt || (err_spurious && !err_clr);
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            pair_buf[wr_idx] <= {ld_ar, ld_ai, ld_br, ld_bi};
        end
    end

endmodule

// File: tb/tb_c_mac_feeder.sv
// Directed bench for c_mac_feeder with a behavioural c_mac stand-in (Q8 products,
// result 10 cycles after the first mac_en), plus mute and forced-valid controls.
module tb_c_mac_feeder;

    logic        clk;
    logic        rst;
    logic        ld_valid;
    logic        ld_ready;
    logic [15:0] ld_ar, ld_ai, ld_br, ld_bi;
    logic        mac_clear, mac_en;
    logic [15:0] mac_ar, mac_ai, mac_br, mac_bi;
    logic        mac_result_valid;
    logic [31:0] mac_r_out, mac_i_out;
    logic        res_valid, res_ready;
    logic [31:0] res_r, res_i;
    logic        err_timeout, err_spurious, err_clr;

    int          n_checks;
    int          n_fail;
    logic [63:0] exp_q[$];

    logic        stub_mute;
    logic        force_rv;
    logic        stub_rv;
    logic [31:0] stub_r, stub_i;
    int          acc_r, acc_i;
    int          lat;

    c_mac_feeder dut (
        .clk(clk), .rst(rst),
        .ld_valid(ld_valid), .ld_ready(ld_ready),
        .ld_ar(ld_ar), .ld_ai(ld_ai), .ld_br(ld_br), .ld_bi(ld_bi),
        .mac_clear(mac_clear), .mac_en(mac_en),
        .mac_ar(mac_ar), .mac_ai(mac_ai), .mac_br(mac_br), .mac_bi(mac_bi),
        .mac_result_valid(mac_result_valid),
        .mac_r_out(mac_r_out), .mac_i_out(mac_i_out),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_r(res_r), .res_i(res_i),
        .err_timeout(err_timeout), .err_spurious(err_spurious), .err_clr(err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mac_result_valid = stub_rv | force_rv;
    assign mac_r_out        = force_rv ? 32'hDEAD_BEEF : stub_r;
    assign mac_i_out        = force_rv ? 32'hBEEF_DEAD : stub_i;

    // MAC stand-in: each beat adds (a*b) >>> 8, result valid in cycle 10 after first beat.
    always @(posedge clk) begin
        if (rst || mac_clear) begin
            acc_r   <= 0;
            acc_i   <= 0;
            lat     <= 0;
            stub_rv <= 1'b0;
            stub_r  <= '0;
            stub_i  <= '0;
        end else begin
            stub_rv <= 1'b0;
            if (mac_en) begin
                acc_r <= acc_r + ((int'($signed(mac_ar)) * int'($signed(mac_br))
                                 - int'($signed(mac_ai)) * int'($signed(mac_bi))) >>> 8);
                acc_i <= acc_i + ((int'($signed(mac_ar)) * int'($signed(mac_bi))
                                 + int'($signed(mac_ai)) * int'($signed(mac_br))) >>> 8);
            end
            if (lat != 0) begin
                if (lat == 9) begin
                    stub_rv <= !stub_mute;
                    stub_r  <= acc_r;
                    stub_i  <= acc_i;
                    lat     <= 0;
                end else begin
                    lat <= lat + 1;
                end
            end else if (mac_en) begin
                lat <= 1;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic send_pair(input logic [15:0] ar, input logic [15:0] ai,
                             input logic [15:0] br, input logic [15:0] bi);
        int n = 0;
        ld_valid = 1'b1;
        ld_ar = ar; ld_ai = ai; ld_br = br; ld_bi = bi;
        while (!ld_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("ld_ready_wait", ld_ready, 1);
        @(negedge clk);
        ld_valid = 1'b0;
        exp_q.push_back({ar, ai, br, bi});
    endtask

    // Called in the cycle after the last accept (the clear cycle).
    task automatic check_burst();
        logic [63:0] e;
        logic [63:0] last;
        last = '0;
        check_eq("clr_pulse", mac_clear, 1);
        check_eq("clr_no_en", mac_en, 0);
        check_eq("ld_ready_drop", ld_ready, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hX;
            check_eq("issue_en", mac_en, 1);
            check_eq("issue_clr", mac_clear, 0);
            check_eq("issue_ops", {mac_ar, mac_ai, mac_br, mac_bi}, e);
            last = e;
        end
        @(negedge clk);
        check_eq("issue_done_en", mac_en, 0);
        check_eq("ops_hold", {mac_ar, mac_ai, mac_br, mac_bi}, last);
    endtask

    task automatic wait_result(input logic [31:0] er, input logic [31:0] ei, output int n);
        n = 0;
        while (!res_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        check_eq("res_valid_wait", res_valid, 1);
        check_eq("res_r", res_r, er);
        check_eq("res_i", res_i, ei);
    endtask

    task automatic handshake();
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check_eq("res_valid_drop", res_valid, 0);
        check_eq("fill_resume", ld_ready, 1);
    endtask

    initial begin
        int n;
        int accepts;
        int k;
        logic seen;
        int          pat [7]   = '{1, 0, 0, 1, 1, 0, 1};
        logic [15:0] st_ar [4] = '{16'd1, 16'd3, 16'd5, 16'd7};
        logic [15:0] st_ai [4] = '{16'd2, 16'd4, 16'd6, 16'd8};

        n_checks = 0; n_fail = 0;
        rst = 1'b1; ld_valid = 1'b0; res_ready = 1'b0; err_clr = 1'b0;
        ld_ar = '0; ld_ai = '0; ld_br = '0; ld_bi = '0;
        stub_mute = 1'b0; force_rv = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_ld_ready", ld_ready, 0);
        check_eq("rst_mac_en", mac_en, 0);
        check_eq("rst_mac_clear", mac_clear, 0);
        check_eq("rst_ops", {mac_ar, mac_ai, mac_br, mac_bi}, 0);
        check_eq("rst_res", {res_valid, res_r, res_i}, 0);
        check_eq("rst_errs", {err_timeout, err_spurious}, 0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("ld_ready_after_rst", ld_ready, 1);

        // Basic dot product 4 x (1.0 * 1.0) in Q8, then output backpressure
        for (int i = 0; i < 4; i++) send_pair(16'd256, 16'd0, 16'd256, 16'd0);
        check_burst();
        wait_result(32'h0000_0400, 32'h0, n);
        check_eq("res_latency", n, 7);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_eq("bp_valid", res_valid, 1);
            check_eq("bp_data", {res_r, res_i}, {32'h0000_0400, 32'h0});
            check_eq("bp_ld_ready", ld_ready, 0);
        end
        handshake();
        check_eq("errs_clean", {err_timeout, err_spurious}, 0);

        // Load stall pattern; issue order follows load order
        accepts = 0; k = 0;
        res_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            ld_valid = (pat[i] != 0);
            ld_ar = st_ar[k]; ld_ai = st_ai[k]; ld_br = 16'd256; ld_bi = 16'd0;
            check_eq("stall_ld_ready", ld_ready, 1);
            if (ld_valid && ld_ready) begin
                accepts++;
                exp_q.push_back({st_ar[k], st_ai[k], 16'd256, 16'd0});
                k = (k < 3) ? k + 1 : k;
            end
            @(negedge clk);
        end
        ld_valid = 1'b0;
        res_ready = 1'b0;
        check_eq("stall_accepts", accepts, 4);
        check_burst();
        wait_result(32'd16, 32'd20, n);
        handshake();

        // Timeout: MAC never answers
        stub_mute = 1'b1;
        for (int i = 0; i < 4; i++) send_pair(16'd9, 16'd9, 16'd9, 16'd9);
        check_burst();
        n = 0; seen = 1'b0;
        while (!err_timeout && n < 60) begin
            @(negedge clk);
            n++;
            seen = seen | res_valid;
        end
        check_eq("timeout_cycles", n, 32);
        check_eq("timeout_clear", mac_clear, 1);
        check_eq("timeout_no_res", seen, 0);
        @(negedge clk);
        check_eq("timeout_clear_once", mac_clear, 0);
        check_eq("timeout_fill", ld_ready, 1);
        check_eq("timeout_issue_none", mac_en, 0);
        check_eq("timeout_sticky", err_timeout, 1);
        stub_mute = 1'b0;
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check_eq("timeout_cleared", err_timeout, 0);

        // Spurious result during FILL; set beats a coincident clear
        force_rv = 1'b1;
        @(negedge clk);
        force_rv = 1'b0;
        check_eq("spur_flag", err_spurious, 1);
        check_eq("spur_res_r", res_r, 32'd16);
        check_eq("spur_no_valid", res_valid, 0);
        force_rv = 1'b1; err_clr = 1'b1;
        @(negedge clk);
        force_rv = 1'b0;
        check_eq("spur_set_wins", err_spurious, 1);
        @(negedge clk);
        err_clr = 1'b0;
        check_eq("spur_cleared", err_spurious, 0);

        // Reset on the second mac_en cycle
        for (int i = 0; i < 4; i++) send_pair(16'd7, 16'd1, 16'd256, 16'd0);
        @(negedge clk);
        check_eq("mid_en0", mac_en, 1);
        @(negedge clk);
        check_eq("mid_en1", mac_en, 1);
        rst = 1'b1;
        @(negedge clk);
        exp_q.delete();
        check_eq("mid_rst_en", mac_en, 0);
        check_eq("mid_rst_outs", {ld_ready, mac_clear, res_valid, res_r, res_i}, 0);
        check_eq("mid_rst_ops", {mac_ar, mac_ai, mac_br, mac_bi}, 0);
        check_eq("mid_rst_errs", {err_timeout, err_spurious}, 0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("mid_rst_ld_ready", ld_ready, 1);
        send_pair(16'd2, 16'd3, 16'd256, 16'd512);
        send_pair(16'hFFFF, 16'd4, 16'd512, 16'd256);
        send_pair(16'd10, 16'd0, 16'hFF00, 16'd0);
        send_pair(16'd0, 16'hFFFB, 16'd0, 16'd256);
        check_burst();
        wait_result(32'hFFFF_FFF1, 32'd14, n);
        handshake();
        check_eq("final_errs", {err_timeout, err_spurious}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
